// File: rtl/hazard_controller.sv
// hazard_controller
// Pipeline hazard sequencer for the five-stage core. It resolves the hazards
// that forwarding cannot: load-use stalls, wrong-path flushes on taken
// branches/jumps, and the start/done handshake with the multi-cycle mul/div
// unit. It also keeps a saturating count of stalled fetch cycles.
//
// Ports
//   clk                 core clock, rising edge
//   rst                 asynchronous active-low reset; forces all outputs to 0
//   MemReadE, RD_E      EX instruction is a load / its destination register
//   Rs1_D, Rs2_D        ID source registers
//   UseRs1_D, UseRs2_D  ID instruction actually reads Rs1 / Rs2
//   PCSrcE              taken branch or jump resolved in EX
//   MdValidE            EX instruction needs the mul/div unit
//   md_done             mul/div result ready (single-cycle pulse)
//   md_start            start pulse to the mul/div unit
//   StallF/D/E          hold PC, IF/ID, ID/EX
//   FlushD/E/M          bubble into IF/ID, ID/EX, EX/MEM
//   md_busy             controller is waiting on the mul/div unit
//   md_error            sticky mul/div timeout flag
//   stall_cnt           saturating count of cycles with StallF=1
//
// state   | meaning
// --------+-----------------------------------------------------------
// RUN     | normal flow; resolves branch flush, load-use, mul/div start
// MD_WAIT | front of pipe frozen until md_done or the wait timer expires
module hazard_controller #(
    parameter int MD_TIMEOUT = 64,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             MemReadE,
    input  logic [4:0]       RD_E,
    input  logic [4:0]       Rs1_D,
    input  logic [4:0]       Rs2_D,
    input  logic             UseRs1_D,
    input  logic             UseRs2_D,
    input  logic             PCSrcE,
    input  logic             MdValidE,
    input  logic             md_done,
    output logic             md_start,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushM,
    output logic             md_busy,
    output logic             md_error,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } state_t;

    // Wait timer counts down from MD_TIMEOUT-1; reaching zero without
    // md_done is the timeout.
    localparam logic [7:0]       WAIT_LOAD = 8'(MD_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_t     state, state_nxt;
    logic [7:0] wait_cnt, wait_nxt;
    logic       luh;
    logic       timeout;
    logic       err_set;

    always_comb begin
        luh = MemReadE && (RD_E != 5'd0) &&
              ((UseRs1_D && (Rs1_D == RD_E)) || (UseRs2_D && (Rs2_D == RD_E)));
    end

    always_comb begin
        md_start  = 1'b0;
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        FlushM    = 1'b0;
        md_busy   = 1'b0;
        timeout   = 1'b0;
        err_set   = 1'b0;
        state_nxt = state;
        wait_nxt  = wait_cnt;

        unique case (state)
            RUN: begin
                if (PCSrcE) begin
                    FlushD = 1'b1;
                    FlushE = 1'b1;
                end else if (luh) begin
                    StallF = 1'b1;
                    StallD = 1'b1;
                    FlushE = 1'b1;
                end else if (MdValidE) begin
                    md_start  = 1'b1;
                    StallF    = 1'b1;
                    StallD    = 1'b1;
                    StallE    = 1'b1;
                    FlushM    = 1'b1;
                    state_nxt = MD_WAIT;
                    wait_nxt  = WAIT_LOAD;
                end
            end
            MD_WAIT: begin
                md_busy = 1'b1;
                timeout = !md_done && (wait_cnt == 8'd0);
                if (md_done || timeout) begin
                    // Release: EX instruction and its result advance next edge.
                    state_nxt = RUN;
                    wait_nxt  = 8'd0;
                    err_set   = timeout;
                end else begin
                    StallF   = 1'b1;
                    StallD   = 1'b1;
                    StallE   = 1'b1;
                    FlushM   = 1'b1;
                    wait_nxt = wait_cnt - 8'd1;
                end
            end
            default: begin
                state_nxt = RUN;
                wait_nxt  = 8'd0;
            end
        endcase

        // Outputs must drop the moment reset asserts, not at the next edge.
        if (!rst) begin
            md_start = 1'b0;
            StallF   = 1'b0;
            StallD   = 1'b0;
            StallE   = 1'b0;
            FlushD   = 1'b0;
            FlushE   = 1'b0;
            FlushM   = 1'b0;
            md_busy  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= RUN;
            wait_cnt <= 8'd0;
            md_error <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            if (err_set) begin
                md_error <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (StallF && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule
